mips_main_controller: RTL and testbench

Multi-cycle main control FSM for the non-pipelined MIPS core. It sequences the shared datapath (memory port, ALU, register file, PC, IR) through the `mips_state_e` states, decoding `op` from the instruction register. It drives all datapath mux selects and write enables and handles the memory-ready handshake. It also keeps a retired-instruction counter and a sticky illegal-opcode flag.

---
 rtl/mips_main_controller.sv | 190 +++++++++++++++++++
 tb/tb_mips_main_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_main_controller.sv
// Multi-cycle main control FSM for the non-pipelined MIPS core: sequences the shared
// datapath per opcode, and tracks retired instructions and illegal opcodes.
module mips_main_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           op,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_src,
  output logic                 branch,
  output logic                 pc_write,
  output logic                 pc_en,
  output logic [3:0]           state,
  output logic                 instr_retired,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic                 illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH         = 4'd0,
    S_DECODE        = 4'd1,
    S_MEMADDR       = 4'd2,
    S_MEMREAD       = 4'd3,
    S_MEMWRITEBACK  = 4'd4,
    S_MEMWRITE      = 4'd5,
    S_EXECUTE       = 4'd6,
    S_ALUWRITEBACK  = 4'd7,
    S_BRANCH        = 4'd8,
    S_ADDIEXECUTE   = 4'd9,
    S_ADDIWRITEBACK = 4'd10,
    S_JUMP          = 4'd11
  } mips_state_e;

  typedef enum logic [5:0] {
    MIPS_RTYPE_OP = 6'h00,
    MIPS_J_OP     = 6'h02,
    MIPS_BEQ_OP   = 6'h04,
    MIPS_BNE_OP   = 6'h05,
    MIPS_ADDI_OP  = 6'h08,
    MIPS_LW_OP    = 6'h23,
    MIPS_SW_OP    = 6'h2B
  } mips_op_e;

  mips_state_e          state_r;
  logic [CNT_WIDTH-1:0] retired_count_r;
  logic                 illegal_r;

  function automatic logic op_legal(input logic [5:0] opcode);
    case (opcode)
      MIPS_RTYPE_OP, MIPS_J_OP, MIPS_BEQ_OP, MIPS_BNE_OP,
      MIPS_ADDI_OP, MIPS_LW_OP, MIPS_SW_OP: op_legal = 1'b1;
      default:                              op_legal = 1'b0;
    endcase
  endfunction

  // State sequencing, retired-instruction counter and sticky illegal-opcode flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= S_FETCH;
      retired_count_r <= '0;
      illegal_r       <= 1'b0;
    end else begin
      if (instr_retired) begin
        retired_count_r <= retired_count_r + CNT_WIDTH'(1);
      end
      if (state_r == S_DECODE && !op_legal(op)) begin
        illegal_r <= 1'b1;
      end
      case (state_r)
        S_FETCH:         if (mem_ready) state_r <= S_DECODE;
        S_DECODE: begin
          case (op)
            MIPS_LW_OP, MIPS_SW_OP:   state_r <= S_MEMADDR;
            MIPS_RTYPE_OP:            state_r <= S_EXECUTE;
            MIPS_BEQ_OP, MIPS_BNE_OP: state_r <= S_BRANCH;
            MIPS_ADDI_OP:             state_r <= S_ADDIEXECUTE;
            MIPS_J_OP:                state_r <= S_JUMP;
            default:                  state_r <= S_FETCH;
          endcase
        end
        S_MEMADDR:       state_r <= (op == MIPS_SW_OP) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:       if (mem_ready) state_r <= S_MEMWRITEBACK;
        S_MEMWRITEBACK:  state_r <= S_FETCH;
        S_MEMWRITE:      if (mem_ready) state_r <= S_FETCH;
        S_EXECUTE:       state_r <= S_ALUWRITEBACK;
        S_ALUWRITEBACK:  state_r <= S_FETCH;
        S_BRANCH:        state_r <= S_FETCH;
        S_ADDIEXECUTE:   state_r <= S_ADDIWRITEBACK;
        S_ADDIWRITEBACK: state_r <= S_FETCH;
        S_JUMP:          state_r <= S_FETCH;
        default:         state_r <= S_FETCH;
      endcase
    end
  end

  // Moore control decode; FETCH gates its loads on mem_ready, MEMWRITE retires on it
  always_comb begin
    iord          = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    branch        = 1'b0;
    pc_write      = 1'b0;
    instr_retired = 1'b0;
    case (state_r)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b     = 2'b11;
        instr_retired = !op_legal(op);
      end
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMREAD: begin
        iord = 1'b1;
      end
      S_MEMWRITEBACK: begin
        mem_to_reg    = 1'b1;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEMWRITE: begin
        iord          = 1'b1;
        mem_write     = 1'b1;
        instr_retired = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWRITEBACK: begin
        reg_dst       = 1'b1;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_src        = 2'b01;
        branch        = 1'b1;
        instr_retired = 1'b1;
      end
      S_ADDIEXECUTE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWRITEBACK: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_JUMP: begin
        pc_src        = 2'b10;
        pc_write      = 1'b1;
        instr_retired = 1'b1;
      end
      default: begin
        instr_retired = 1'b0;
      end
    endcase
  end

  // BNE inverts the sense of the zero flag
  assign pc_en         = pc_write | (branch & (zero ^ (op == MIPS_BNE_OP)));
  assign state         = state_r;
  assign retired_count = retired_count_r;
  assign illegal_op    = illegal_r;

endmodule

// File: tb/tb_mips_main_controller.sv
// Self-checking bench for mips_main_controller: directed reset/abort/wrap sequences,
// a vector table of instructions, and randomized instruction streams against a path model.
module tb_mips_main_controller;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] op = 6'h00;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;

  logic iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic branch, pc_write, pc_en, instr_retired, illegal_op;
  logic [3:0] state;
  logic [31:0] retired_count;

  logic w_iord, w_mem_write, w_ir_write, w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_alu_op, w_pc_src;
  logic w_branch, w_pc_write, w_pc_en, w_instr_retired, w_illegal_op;
  logic [3:0] w_state;
  logic [1:0] w_retired_count;

  logic [14:0] act_ctrl, w_ctrl;
  assign act_ctrl = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                     alu_src_b, alu_op, pc_src, branch, pc_write};
  assign w_ctrl   = {w_iord, w_mem_write, w_ir_write, w_reg_dst, w_mem_to_reg, w_reg_write,
                     w_alu_src_a, w_alu_src_b, w_alu_op, w_pc_src, w_branch, w_pc_write};

  mips_main_controller #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .branch(branch),
    .pc_write(pc_write), .pc_en(pc_en), .state(state), .instr_retired(instr_retired),
    .retired_count(retired_count), .illegal_op(illegal_op)
  );

  // Narrow counter instance so wrap-around is reached within a few instructions
  mips_main_controller #(.CNT_WIDTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(w_iord), .mem_write(w_mem_write), .ir_write(w_ir_write), .reg_dst(w_reg_dst),
    .mem_to_reg(w_mem_to_reg), .reg_write(w_reg_write), .alu_src_a(w_alu_src_a),
    .alu_src_b(w_alu_src_b), .alu_op(w_alu_op), .pc_src(w_pc_src), .branch(w_branch),
    .pc_write(w_pc_write), .pc_en(w_pc_en), .state(w_state), .instr_retired(w_instr_retired),
    .retired_count(w_retired_count), .illegal_op(w_illegal_op)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count = 32'd0;
  logic exp_illegal = 1'b0;
  logic [14:0] exp_ctrl [0:15];

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         lat;
    int         rstate;
    logic       rpc;
    logic       rrw;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [14:0] mk(input logic iord_v, mw, irw, rd, m2r, rw, asa,
                                     input logic [1:0] asb, aop, psrc,
                                     input logic br, pw);
    return {iord_v, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, br, pw};
  endfunction

  function automatic logic legal(input logic [5:0] o);
    return (o == OP_R) || (o == OP_J) || (o == OP_BEQ) || (o == OP_BNE) ||
           (o == OP_ADDI) || (o == OP_LW) || (o == OP_SW);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Runs one instruction cycle by cycle, following the state path the opcode must take.
  task automatic run_instr(input logic [5:0] o, input bit rnd, input logic zbit,
                           input int stall_st, input int stall_n,
                           output int lat, output int mw_cyc, output int ret_state,
                           output logic ret_pc_en, output logic ret_rw);
    int path[$];
    int idx, stalls, cur;
    bit done, waiting, ret_exp;
    logic [14:0] exp;
    logic epc;
    case (o)
      OP_LW:          path = '{0, 1, 2, 3, 4};
      OP_SW:          path = '{0, 1, 2, 5};
      OP_R:           path = '{0, 1, 6, 7};
      OP_BEQ, OP_BNE: path = '{0, 1, 8};
      OP_ADDI:        path = '{0, 1, 9, 10};
      OP_J:           path = '{0, 1, 11};
      default:        path = '{0, 1};
    endcase
    idx = 0; stalls = 0; lat = 0; mw_cyc = 0; ret_state = -1;
    ret_pc_en = 1'b0; ret_rw = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      op = o;
      zero = rnd ? 1'($urandom_range(0, 1)) : zbit;
      if (rnd) mem_ready = ($urandom_range(0, 3) != 0);
      else mem_ready = !(idx < path.size() && path[idx] == stall_st && stalls < stall_n);
      #1;
      cur = (idx < path.size()) ? path[idx] : 15;
      waiting = (cur == 0 || cur == 3 || cur == 5) && !mem_ready;
      ret_exp = (idx == path.size() - 1) && !waiting;
      exp = exp_ctrl[cur];
      if (cur == 0 && !mem_ready) exp = exp & ~15'h1001;
      epc = (cur == 8) ? ((o == OP_BNE) ? ~zero : zero) : exp[0];
      chk("state", 64'(state), 64'(cur));
      chk("ctrl", 64'(act_ctrl), 64'(exp));
      chk("pc_en", 64'(pc_en), 64'(epc));
      chk("instr_retired", 64'(instr_retired), 64'(ret_exp));
      chk("retired_count", 64'(retired_count), 64'(exp_count));
      chk("illegal_op", 64'(illegal_op), 64'(exp_illegal));
      chk("narrow_count", 64'(w_retired_count), 64'(exp_count[1:0]));
      chk("narrow_outputs", 64'({w_ctrl, w_pc_en, w_state, w_instr_retired, w_illegal_op}),
          64'({exp, epc, 4'(cur), ret_exp, exp_illegal}));
      if (mem_write) mw_cyc++;
      if (instr_retired) begin
        lat = cyc + 1; ret_state = int'(state); ret_pc_en = pc_en; ret_rw = reg_write;
        done = 1'b1;
      end
      if (ret_exp) exp_count = exp_count + 32'd1;
      if (cur == 1 && !legal(o)) exp_illegal = 1'b1;
      if (cur == stall_st && !mem_ready) stalls++;
      if (!waiting) idx++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: op %0h never retired within 60 cycles", o);
    end
  endtask

  initial begin
    int lat, mw, rs;
    logic rpc, rrw;
    logic [5:0] ro;

    exp_ctrl[0]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b1);
    exp_ctrl[1]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0);
    exp_ctrl[2]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0);
    exp_ctrl[3]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    exp_ctrl[4]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    exp_ctrl[5]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    exp_ctrl[6]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0);
    exp_ctrl[7]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    exp_ctrl[8]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0);
    exp_ctrl[9]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0);
    exp_ctrl[10] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    exp_ctrl[11] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,1'b1);
    for (int i = 12; i < 16; i++) exp_ctrl[i] = 15'h0000;

    tbl[0] = '{OP_LW,   1'b0, 5, 4,  1'b0, 1'b1};
    tbl[1] = '{OP_SW,   1'b0, 4, 5,  1'b0, 1'b0};
    tbl[2] = '{OP_ADDI, 1'b0, 4, 10, 1'b0, 1'b1};
    tbl[3] = '{OP_R,    1'b0, 4, 7,  1'b0, 1'b1};
    tbl[4] = '{OP_J,    1'b0, 3, 11, 1'b1, 1'b0};
    tbl[5] = '{OP_BEQ,  1'b1, 3, 8,  1'b1, 1'b0};
    tbl[6] = '{OP_BEQ,  1'b0, 3, 8,  1'b0, 1'b0};
    tbl[7] = '{OP_BNE,  1'b0, 3, 8,  1'b1, 1'b0};
    tbl[8] = '{OP_BNE,  1'b1, 3, 8,  1'b0, 1'b0};
    tbl[9] = '{6'h3F,   1'b0, 2, 1,  1'b0, 1'b0};

    // Reset state and FETCH decoding while held in reset
    rst_n = 1'b0; mem_ready = 1'b1; op = OP_LW;
    #2;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_ctrl_ready", 64'(act_ctrl), 64'(exp_ctrl[0]));
    chk("rst_pc_en_ready", 64'(pc_en), 64'd1);
    chk("rst_count", 64'(retired_count), 64'd0);
    chk("rst_illegal", 64'(illegal_op), 64'd0);
    mem_ready = 1'b0; #1;
    chk("rst_ctrl_notready", 64'(act_ctrl), 64'(exp_ctrl[0] & ~15'h1001));
    chk("rst_pc_en_notready", 64'(pc_en), 64'd0);
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_state", 64'(state), 64'd0);

    // Abort an R-type in EXECUTE with reset
    @(negedge clk);
    rst_n = 1'b1; op = OP_R; mem_ready = 1'b1; #1;
    chk("abort_fetch", 64'(state), 64'd0);
    @(negedge clk); #1;
    chk("abort_decode", 64'(state), 64'd1);
    @(negedge clk); #1;
    chk("abort_execute", 64'(state), 64'd6);
    rst_n = 1'b0; #1;
    chk("abort_state", 64'(state), 64'd0);
    chk("abort_count", 64'(retired_count), 64'd0);
    chk("abort_retire", 64'(instr_retired), 64'd0);
    mem_ready = 1'b0; #1;
    rst_n = 1'b1;
    exp_count = 32'd0; exp_illegal = 1'b0;

    // Narrow counter wraps from all-ones to zero on a J
    for (int i = 0; i < 3; i++) run_instr(OP_J, 1'b0, 1'b0, -1, 0, lat, mw, rs, rpc, rrw);
    @(posedge clk); #1;
    chk("wrap_pre", 64'(w_retired_count), 64'd3);
    run_instr(OP_J, 1'b0, 1'b0, -1, 0, lat, mw, rs, rpc, rrw);
    @(posedge clk); #1;
    chk("wrap_post", 64'(w_retired_count), 64'd0);
    chk("wrap_wide", 64'(retired_count), 64'd4);

    // Vector table with mem_ready tied high
    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].op, 1'b0, tbl[i].z, -1, 0, lat, mw, rs, rpc, rrw);
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("tbl%0d_ret_state", i), 64'(rs), 64'(tbl[i].rstate));
      chk($sformatf("tbl%0d_ret_pc_en", i), 64'(rpc), 64'(tbl[i].rpc));
      chk($sformatf("tbl%0d_ret_reg_write", i), 64'(rrw), 64'(tbl[i].rrw));
    end

    // SW held off three cycles in MEMWRITE
    run_instr(OP_SW, 1'b0, 1'b0, 5, 3, lat, mw, rs, rpc, rrw);
    chk("sw_stall_latency", 64'(lat), 64'd7);
    chk("sw_stall_mem_write_cycles", 64'(mw), 64'd4);
    // LW held off in FETCH, then in MEMREAD
    run_instr(OP_LW, 1'b0, 1'b0, 0, 2, lat, mw, rs, rpc, rrw);
    chk("lw_fetch_stall_latency", 64'(lat), 64'd7);
    run_instr(OP_LW, 1'b0, 1'b0, 3, 2, lat, mw, rs, rpc, rrw);
    chk("lw_read_stall_latency", 64'(lat), 64'd7);

    // Randomized instruction stream with random mem_ready and zero
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: ro = OP_LW;
        1: ro = OP_SW;
        2: ro = OP_R;
        3: ro = OP_BEQ;
        4: ro = OP_BNE;
        5: ro = OP_ADDI;
        6: ro = OP_J;
        default: begin
          do ro = 6'($urandom_range(0, 63)); while (legal(ro));
        end
      endcase
      run_instr(ro, 1'b1, 1'b0, -1, 0, lat, mw, rs, rpc, rrw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
